// File: rtl/irq_detect_arbiter.sv
// IRQ pin sampler, level/edge detector, pending-flag bank and priority arbiter
// driving a registered request/acknowledge handshake. Optional IRQ_FILTER_EN adds a 3-sample pin filter.
module irq_detect_arbiter #(
  parameter int unsigned N_IRQ    = 16,
  parameter int unsigned VEC_BASE = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_pin,
  input  logic [31:0]      INTCR_dataout,
  input  logic [31:0]      ISCRL_dataout,
  input  logic [31:0]      ISCRH_dataout,
  input  logic [31:0]      IER_dataout,
  input  logic [31:0]      IPRA_dataout,
  input  logic [31:0]      IPRB_dataout,
  input  logic [31:0]      IPRC_dataout,
  input  logic [31:0]      IPRD_dataout,
  input  logic [2:0]       cpu_mask,
  input  logic             irq_ack,
  input  logic [N_IRQ-1:0] isr_clr,
  output logic             irq_req,
  output logic [7:0]       irq_vec,
  output logic [2:0]       irq_level,
  output logic [N_IRQ-1:0] isr_status
);

  localparam int unsigned VEC_W = 8;
  localparam int unsigned LVL_W = 3;
  localparam int unsigned IDX_W = 4;
  localparam logic [VEC_W-1:0] VEC_BASE8 = VEC_W'(VEC_BASE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t                state_q;
  logic                  irq_req_q;
  logic [VEC_W-1:0]      irq_vec_q;
  logic [LVL_W-1:0]      irq_level_q;

  logic [N_IRQ-1:0]      sync1_q, syn_q, prev_q;
  logic [N_IRQ-1:0]      filt_c;
  logic [N_IRQ-1:0]      isr_q, isr_d;
  logic [N_IRQ-1:0]      ev_c, clr_c, elig_c;
  logic [N_IRQ-1:0][1:0] sense_c;
  logic [N_IRQ-1:0][LVL_W-1:0] prio_c;

  logic                  ack_fire_c;
  logic [VEC_W-1:0]      ack_idx_c;
  logic [1:0]            intm_c;
  logic                  win_found_c;
  logic [IDX_W-1:0]      win_idx_c;
  logic [LVL_W-1:0]      win_lvl_c;
  logic [VEC_W-1:0]      win_vec_c;
  logic                  unused_regbits_c;

  // Register bits not decoded here are folded into a dummy sink.
  assign unused_regbits_c = ^{INTCR_dataout, ISCRL_dataout, ISCRH_dataout, IER_dataout,
                              IPRA_dataout, IPRB_dataout, IPRC_dataout, IPRD_dataout};

  // Two-flop synchronizer; reset to inactive-high so release creates no edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '1;
      syn_q   <= '1;
      prev_q  <= '1;
    end else begin
      sync1_q <= irq_pin;
      syn_q   <= sync1_q;
      prev_q  <= filt_c;
    end
  end

`ifdef IRQ_FILTER_EN
  logic [N_IRQ-1:0] hist1_q, hist2_q, stable_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist1_q <= '1;
      hist2_q <= '1;
    end else begin
      hist1_q <= syn_q;
      hist2_q <= hist1_q;
    end
  end

  // prev_q holds the last filtered value; it only follows syn after 3 equal samples.
  assign stable_c = ~(syn_q ^ hist1_q) & ~(hist1_q ^ hist2_q);
  assign filt_c   = (stable_c & syn_q) | (~stable_c & prev_q);
`else
  assign filt_c = syn_q;
`endif

  // Per-source sense and priority field extraction.
  for (genvar n = 0; n < N_IRQ; n++) begin : g_src
    localparam int unsigned K  = n / 4;
    localparam int unsigned SH = 12 - 4 * (n % 4);
    if (n < 8) begin : g_lo
      assign sense_c[n] = ISCRL_dataout[2*n +: 2];
    end else begin : g_hi
      assign sense_c[n] = ISCRH_dataout[2*(n-8) +: 2];
    end
    if (K == 0) begin : g_pa
      assign prio_c[n] = IPRA_dataout[SH +: LVL_W];
    end else if (K == 1) begin : g_pb
      assign prio_c[n] = IPRB_dataout[SH +: LVL_W];
    end else if (K == 2) begin : g_pc
      assign prio_c[n] = IPRC_dataout[SH +: LVL_W];
    end else begin : g_pd
      assign prio_c[n] = IPRD_dataout[SH +: LVL_W];
    end
  end

  assign ack_fire_c = (state_q == ST_REQ) && irq_ack;
  assign ack_idx_c  = irq_vec_q - VEC_BASE8;

  // Pending flag next-state: level sources track the pin, edge sources latch with set priority.
  always_comb begin
    ev_c  = '0;
    clr_c = '0;
    isr_d = isr_q;
    for (int n = 0; n < N_IRQ; n++) begin
      case (sense_c[n])
        2'b01:   ev_c[n] = prev_q[n] & ~filt_c[n];
        2'b10:   ev_c[n] = ~prev_q[n] & filt_c[n];
        2'b11:   ev_c[n] = prev_q[n] ^ filt_c[n];
        default: ev_c[n] = 1'b0;
      endcase
      clr_c[n] = isr_clr[n] | (ack_fire_c && (ack_idx_c == VEC_W'(n)));
      if (sense_c[n] == 2'b00) begin
        isr_d[n] = ~filt_c[n];
      end else begin
        isr_d[n] = ev_c[n] | (isr_q[n] & ~clr_c[n]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      isr_q <= '0;
    end else begin
      isr_q <= isr_d;
    end
  end

  // Arbitration: fixed mode picks lowest index, priority mode picks highest level.
  assign intm_c = INTCR_dataout[5:4];

  always_comb begin
    elig_c      = isr_q & IER_dataout[N_IRQ-1:0];
    win_found_c = 1'b0;
    win_idx_c   = '0;
    win_lvl_c   = '0;
    for (int n = 0; n < N_IRQ; n++) begin
      if (elig_c[n]) begin
        if (intm_c == 2'b00) begin
          if (!win_found_c) begin
            win_found_c = 1'b1;
            win_idx_c   = IDX_W'(n);
            win_lvl_c   = prio_c[n];
          end
        end else if (!win_found_c || (prio_c[n] > win_lvl_c)) begin
          win_found_c = 1'b1;
          win_idx_c   = IDX_W'(n);
          win_lvl_c   = prio_c[n];
        end
      end
    end
    if (intm_c == 2'b00) begin
      if (cpu_mask[2]) win_found_c = 1'b0;
    end else if (win_lvl_c <= cpu_mask) begin
      win_found_c = 1'b0;
    end
  end

  assign win_vec_c = VEC_BASE8 + VEC_W'(win_idx_c);

  // Handshake FSM; vector and level keep re-registering in REQ so a better source preempts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      irq_req_q   <= 1'b0;
      irq_vec_q   <= '0;
      irq_level_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_found_c) begin
            state_q     <= ST_REQ;
            irq_req_q   <= 1'b1;
            irq_vec_q   <= win_vec_c;
            irq_level_q <= win_lvl_c;
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            state_q   <= ST_ACK;
            irq_req_q <= 1'b0;
          end else if (win_found_c) begin
            irq_vec_q   <= win_vec_c;
            irq_level_q <= win_lvl_c;
          end else begin
            state_q   <= ST_IDLE;
            irq_req_q <= 1'b0;
          end
        end
        ST_ACK: begin
          state_q   <= ST_IDLE;
          irq_req_q <= 1'b0;
        end
        default: begin
          state_q   <= ST_IDLE;
          irq_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign irq_req    = irq_req_q;
  assign irq_vec    = irq_vec_q;
  assign irq_level  = irq_level_q;
  assign isr_status = isr_q;

endmodule

// File: tb/tb_irq_detect_arbiter.sv
// Scoreboard bench for irq_detect_arbiter: stimulus queues timestamped expectations, a monitor compares.
module tb_irq_detect_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] irq_pin;
  logic [31:0] intcr, iscrl, iscrh, ier, ipra, iprb, iprc, iprd;
  logic [2:0]  cpu_mask;
  logic        irq_ack;
  logic [15:0] isr_clr;
  logic        irq_req;
  logic [7:0]  irq_vec;
  logic [2:0]  irq_level;
  logic [15:0] isr_status;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          tcyc;
    string       name;
    bit          chk_req;
    logic        req;
    bit          chk_vl;
    logic [7:0]  vec;
    logic [2:0]  lvl;
    logic [15:0] care;
    logic [15:0] isr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  bit   mon_ok;

  irq_detect_arbiter #(.N_IRQ(16), .VEC_BASE(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .irq_pin       (irq_pin),
    .INTCR_dataout (intcr),
    .ISCRL_dataout (iscrl),
    .ISCRH_dataout (iscrh),
    .IER_dataout   (ier),
    .IPRA_dataout  (ipra),
    .IPRB_dataout  (iprb),
    .IPRC_dataout  (iprc),
    .IPRD_dataout  (iprd),
    .cpu_mask      (cpu_mask),
    .irq_ack       (irq_ack),
    .isr_clr       (isr_clr),
    .irq_req       (irq_req),
    .irq_vec       (irq_vec),
    .irq_level     (irq_level),
    .isr_status    (isr_status)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop every expectation due at this cycle and compare against the outputs.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].tcyc <= cyc) begin
      mon_e  = sb_q.pop_front();
      mon_ok = 1'b1;
      checks++;
      if (mon_e.tcyc != cyc) mon_ok = 1'b0;
      if (mon_e.chk_req && (irq_req !== mon_e.req)) mon_ok = 1'b0;
      if (mon_e.chk_vl && ((irq_vec !== mon_e.vec) || (irq_level !== mon_e.lvl))) mon_ok = 1'b0;
      if ((isr_status & mon_e.care) !== (mon_e.isr & mon_e.care)) mon_ok = 1'b0;
      if (!mon_ok) begin
        failures++;
        $display("FAIL %s cyc=%0d(due %0d): got req=%0b vec=%0d lvl=%0d isr=%h, want req=%0b vec=%0d lvl=%0d isr=%h care=%h",
                 mon_e.name, cyc, mon_e.tcyc, irq_req, irq_vec, irq_level, isr_status,
                 mon_e.req, mon_e.vec, mon_e.lvl, mon_e.isr, mon_e.care);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // k = 0 means the next rising edge after this negedge.
  task automatic push(input int k, input string nm, input bit cr, input logic r, input bit cv,
                      input logic [7:0] v, input logic [2:0] l, input logic [15:0] care,
                      input logic [15:0] iv);
    exp_t e;
    int   i;
    e.tcyc = cyc + 1 + k; e.name = nm; e.chk_req = cr; e.req = r; e.chk_vl = cv;
    e.vec = v; e.lvl = l; e.care = care; e.isr = iv;
    i = 0;
    while (i < sb_q.size() && sb_q[i].tcyc <= e.tcyc) i++;
    sb_q.insert(i, e);
  endtask

  task automatic exp_req(input int k, input string nm, input logic r, input logic [7:0] v,
                         input logic [2:0] l);
    push(k, nm, 1'b1, r, r, v, l, 16'h0000, 16'h0000);
  endtask

  task automatic exp_isr(input int k, input string nm, input logic [15:0] care, input logic [15:0] iv);
    push(k, nm, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0, care, iv);
  endtask

  task automatic exp_zero(input int k, input string nm);
    push(k, nm, 1'b1, 1'b0, 1'b1, 8'd0, 3'd0, 16'hFFFF, 16'h0000);
  endtask

  initial begin
    rst = 1'b1; irq_pin = 16'hFFFF; cpu_mask = 3'd0; irq_ack = 1'b0; isr_clr = 16'h0000;
    intcr = '0; iscrl = '0; iscrh = '0; ier = '0; ipra = '0; iprb = '0; iprc = '0; iprd = '0;

    // Reset held, then released with idle pins
    tick(1);
    for (int i = 0; i < 20; i++) exp_zero(i, "reset_hold");
    tick(20);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) exp_zero(i, "reset_release");
    tick(5);

    // IRQ3 falling edge, priority mode
    iscrl[7:6] = 2'b01; ier[3] = 1'b1; intcr[5:4] = 2'b10; ipra[2:0] = 3'd5; cpu_mask = 3'd2;
    tick(1);
    irq_pin[3] = 1'b0;
    exp_isr(1, "irq3_isr_e1", 16'h0008, 16'h0000);
    exp_req(1, "irq3_noreq_e1", 1'b0, 8'd0, 3'd0);
    exp_isr(2, "irq3_isr_e2", 16'h0008, 16'h0008);
    exp_req(2, "irq3_noreq_e2", 1'b0, 8'd0, 3'd0);
    exp_req(3, "irq3_req_e3", 1'b1, 8'd67, 3'd5);
    tick(4);
    irq_ack = 1'b1;
    exp_req(0, "irq3_ack_drop", 1'b0, 8'd0, 3'd0);
    exp_isr(0, "irq3_ack_clr", 16'h0008, 16'h0000);
    tick(1);
    irq_ack = 1'b0;
    exp_req(0, "irq3_ack_state", 1'b0, 8'd0, 3'd0);
    tick(2);

    // IRQ1 (level 3) and IRQ9 (level 6) pend together
    iscrl[3:2] = 2'b01; iscrh[3:2] = 2'b01; ier[1] = 1'b1; ier[9] = 1'b1;
    ipra[10:8] = 3'd3; iprc[10:8] = 3'd6;
    tick(1);
    irq_pin[1] = 1'b0; irq_pin[9] = 1'b0;
    exp_req(3, "prio_hi", 1'b1, 8'd73, 3'd6);
    tick(4);
    irq_ack = 1'b1;
    exp_req(0, "prio_hi_ack", 1'b0, 8'd0, 3'd0);
    exp_isr(0, "prio_hi_clr", 16'h0202, 16'h0002);
    tick(1);
    irq_ack = 1'b0;
    exp_req(0, "prio_gap", 1'b0, 8'd0, 3'd0);
    exp_req(1, "prio_lo", 1'b1, 8'd65, 3'd3);
    tick(2);
    irq_ack = 1'b1;
    exp_req(0, "prio_lo_ack", 1'b0, 8'd0, 3'd0);
    exp_isr(0, "prio_lo_clr", 16'h0002, 16'h0000);
    tick(1);
    irq_ack = 1'b0;
    tick(2);

    // Equal levels on IRQ2 and IRQ5: lower index first
    irq_pin[1] = 1'b1; irq_pin[9] = 1'b1; irq_pin[3] = 1'b1;
    iscrl[5:4] = 2'b01; iscrl[11:10] = 2'b01; ier[2] = 1'b1; ier[5] = 1'b1;
    ipra[6:4] = 3'd4; iprb[10:8] = 3'd4;
    tick(1);
    irq_pin[2] = 1'b0; irq_pin[5] = 1'b0;
    exp_req(3, "tie_low_idx", 1'b1, 8'd66, 3'd4);
    tick(4);
    irq_ack = 1'b1;
    exp_req(0, "tie_ack1", 1'b0, 8'd0, 3'd0);
    tick(1);
    irq_ack = 1'b0;
    exp_req(1, "tie_second", 1'b1, 8'd69, 3'd4);
    tick(2);
    irq_ack = 1'b1;
    exp_req(0, "tie_ack2", 1'b0, 8'd0, 3'd0);
    exp_isr(0, "tie_clr", 16'h0024, 16'h0000);
    tick(1);
    irq_ack = 1'b0; irq_pin[2] = 1'b1; irq_pin[5] = 1'b1;
    tick(3);

    // Masking of IRQ9 level 6
    cpu_mask = 3'd6;
    tick(1);
    irq_pin[9] = 1'b0;
    for (int k = 0; k < 7; k++) exp_req(k, "mask_equal", 1'b0, 8'd0, 3'd0);
    exp_isr(3, "mask_pending", 16'h0200, 16'h0200);
    tick(7);
    cpu_mask = 3'd5;
    exp_req(0, "mask_below", 1'b1, 8'd73, 3'd6);
    tick(1);
    intcr[5:4] = 2'b00; cpu_mask = 3'd3;
    exp_req(0, "fixed_unmasked", 1'b1, 8'd73, 3'd6);
    tick(1);
    cpu_mask = 3'd4;
    exp_req(0, "fixed_masked", 1'b0, 8'd0, 3'd0);
    exp_req(2, "fixed_masked_hold", 1'b0, 8'd0, 3'd0);
    tick(3);
    intcr[5:4] = 2'b10; cpu_mask = 3'd2;
    exp_req(0, "prio_restored", 1'b1, 8'd73, 3'd6);
    tick(1);
    irq_ack = 1'b1;
    exp_req(0, "mask_ack", 1'b0, 8'd0, 3'd0);
    exp_isr(0, "mask_ack_clr", 16'h0200, 16'h0000);
    tick(1);
    irq_ack = 1'b0; irq_pin[9] = 1'b1;
    tick(3);

    // Level-sensitive IRQ0
    ier[0] = 1'b1; ipra[14:12] = 3'd2; cpu_mask = 3'd0;
    tick(1);
    irq_pin[0] = 1'b0;
    exp_isr(2, "lvl_isr", 16'h0001, 16'h0001);
    exp_req(3, "lvl_req", 1'b1, 8'd64, 3'd2);
    tick(4);
    isr_clr[0] = 1'b1;
    exp_isr(0, "lvl_clr_noeff", 16'h0001, 16'h0001);
    exp_req(0, "lvl_req_hold", 1'b1, 8'd64, 3'd2);
    tick(1);
    isr_clr = 16'h0000; irq_pin[0] = 1'b1;
    exp_isr(2, "lvl_isr_release", 16'h0001, 16'h0000);
    exp_req(3, "lvl_req_release", 1'b0, 8'd0, 3'd0);
    tick(4);

    // Rising-edge IRQ6 and both-edge IRQ7 (not enabled)
    iscrl[13:12] = 2'b10; iscrl[15:14] = 2'b11;
    tick(1);
    irq_pin[6] = 1'b0; irq_pin[7] = 1'b0;
    exp_isr(2, "rise_ignores_fall", 16'h00C0, 16'h0080);
    tick(4);
    irq_pin[6] = 1'b1;
    exp_isr(2, "rise_sets", 16'h0040, 16'h0040);
    tick(4);
    isr_clr = 16'h00C0;
    exp_isr(0, "edge_sw_clr", 16'h00C0, 16'h0000);
    tick(1);
    isr_clr = 16'h0000; irq_pin[7] = 1'b1;
    exp_isr(2, "both_rise", 16'h0080, 16'h0080);
    tick(4);
    isr_clr = 16'h0080;
    tick(1);
    isr_clr = 16'h0000;

    // IRQ4 event and clear in the same cycle: set wins
    iscrl[9:8] = 2'b01;
    tick(1);
    irq_pin[4] = 1'b0;
    exp_isr(2, "set_beats_clr", 16'h0010, 16'h0010);
    tick(2);
    isr_clr[4] = 1'b1;
    tick(1);
    isr_clr = 16'h0000;
    tick(2);

    // Reset in REQ abandons the request; a later ack does nothing
    ier[4] = 1'b1; iprb[14:12] = 3'd3;
    exp_req(0, "rst_pre_req", 1'b1, 8'd68, 3'd3);
    tick(1);
    irq_pin[4] = 1'b1;
    tick(3);
    rst = 1'b1;
    exp_zero(0, "rst_mid_req");
    tick(1);
    rst = 1'b0; irq_ack = 1'b1;
    exp_zero(0, "ack_after_rst");
    tick(1);
    irq_ack = 1'b0;
    for (int k = 0; k < 4; k++) exp_zero(k, "post_rst_idle");
    tick(5);

    for (int i = 0; i < 50 && sb_q.size() > 0; i++) tick(1);
    if (sb_q.size() > 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations never reached, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_detect_arbiter.md
Name: irq_detect_arbiter

Overview:
- Downstream consumer of the interrupt register bank.
- Samples external active-low IRQ pins and detects level or edge events per ISCR sense control.
- Keeps a per-source pending flag (ISR) gated by IER, and arbitrates by IPR priority under INTCR mode.
- Presents one registered request (vector plus level) to the CPU, with a request/acknowledge handshake.

Parameters:
- N_IRQ, 16: number of IRQ pins, legal 1..16; sources above N_IRQ-1 are ignored.
- VEC_BASE, 64: vector number of IRQ0; irq_vec = VEC_BASE + IRQ index, modulo 256.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- irq_pin  in  N_IRQ  external IRQ lines, active-low, asynchronous
- INTCR_dataout  in  32  INTM = bits [5:4]
- ISCRL_dataout  in  32  IRQn sense = bits [2n+1:2n], n=0..7
- ISCRH_dataout  in  32  IRQn sense = bits [2(n-8)+1:2(n-8)], n=8..15
- IER_dataout  in  32  bit n enables IRQn
- IPRA_dataout..IPRD_dataout  in  32 each  4 sources per register, in index order:
  - IPRA covers IRQ0-3, IPRB IRQ4-7, IPRC IRQ8-11, IPRD IRQ12-15
  - IRQ 4k+0 = [14:12], 4k+1 = [10:8], 4k+2 = [6:4], 4k+3 = [2:0]
- cpu_mask  in  3  CPU interrupt mask level
- irq_ack  in  1  CPU accepts the current request (single-cycle pulse)
- isr_clr  in  N_IRQ  software clear pulses for pending flags
- irq_req  out  1  interrupt request to CPU
- irq_vec  out  8  vector of the request
- irq_level  out  3  priority of the request
- isr_status  out  N_IRQ  pending flags

Behaviour:
- Reset (rst=1 at a clk edge):
  - Synchronizer and previous-sample flops set to all ones (inactive), so reset release cannot create a false falling edge.
  - isr=0, state=IDLE, irq_req=0, irq_vec=0, irq_level=0.
  - Reset mid-handshake abandons the request; a later irq_ack is ignored.
- Synchronizer: 2 flops per pin; "syn" = second stage; "prev" = syn delayed by 1 cycle.
- Sense per IRQ:
  - 00 = low level: isr[n] = ~syn[n] each cycle; isr_clr and ack have no effect.
  - 01 = falling edge: event = prev & ~syn.
  - 10 = rising edge: event = ~prev & syn.
  - 11 = both edges: event = prev ^ syn.
- Edge-mode flags: set on event; cleared by isr_clr[n] or by ack of source n. A set in the same cycle as a clear wins.
- Latency: pin change before edge 0 → isr set at edge 2 → irq_req=1 at edge 3.
- Eligible source: isr[n] & IER[n].
- INTM=00 (fixed mode):
  - Winner is the lowest eligible index; irq_level reports its IPR field.
  - All sources are masked when cpu_mask[2]=1.
- INTM=10, 01 or 11 (priority mode):
  - Winner is the highest IPR level; ties go to the lower index.
  - A request is made only if level > cpu_mask, so level 0 never requests.
- FSM, with irq_req registered as (state==REQ):
  - IDLE: a winner exists → REQ; irq_vec and irq_level register the winner.
  - REQ: vec and level re-register every cycle, so a higher-priority arrival before ack preempts.
  - REQ with no winner (level released, IER cleared, mask raised) → IDLE; irq_req falls on the next edge.
  - REQ with irq_ack=1 → ACK; the source given by the irq_vec currently registered gets its edge flag cleared.
  - ACK: irq_req=0; go to IDLE unconditionally, so the next request appears no earlier than 2 cycles after ack.
  - irq_ack outside REQ is ignored.
- Register changes take effect on the next arbitration cycle.
- A sense change can produce one spurious event; this is accepted and documented for software.

Optional Feature:
- IRQ_FILTER_EN defined:
  - Per-pin 3-sample stability filter after the synchronizer.
  - Filtered value updates only when the last 3 syn samples are equal; edge and level logic use the filtered value.
  - Adds 2 cycles of latency (irq_req at edge 5).
  - Pulses shorter than 3 cycles are rejected.
- Not defined: filtered = syn.

Test Plan:
- Reset, pins held 1, all regs 0 → irq_req=0, irq_vec=0, irq_level=0, isr_status=0 for 20 cycles; release reset → still no request.
- IRQ3 falling edge (ISCRL[7:6]=01, IER[3]=1, INTM=10, IPRA[2:0]=5, cpu_mask=2), pin3 1→0 before edge 0:
  - isr_status[3]=1 at edge 2; irq_req=1, irq_vec=67, irq_level=5 at edge 3.
  - 1-cycle irq_ack → irq_req=0 and isr_status[3]=0 on the next edge.
- Priority: IRQ1 (IPRA[10:8]=3) and IRQ9 (IPRC[10:8]=6) pend together → vec 73, level 6; after ack → vec 65, level 3. Equal levels on IRQ2 and IRQ5 → vec 66.
- Masking: only IRQ9 level 6 pending, cpu_mask=6 → no request; cpu_mask=5 → irq_req=1 one edge later. INTM=00 with cpu_mask[2]=1 → no request.
- Level mode, IRQ0 (sense 00):
  - Pin low → request.
  - Pin high while in REQ, no ack → irq_req=0 within 3 edges.
  - isr_clr[0] while low → isr_status[0] stays 1.
- Same-cycle falling event and isr_clr on IRQ4 → isr_status[4]=1. rst=1 during REQ → all outputs 0 on the next edge; a following irq_ack is ignored.
